// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - EX->LSU pipeline stage: effective address, single-outstanding data-memory port, load alignment and write-back forwarding.
module lsu_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_flag_i,
    input  logic [1:0]  LSU_type_i,
    input  logic        store_flag_i,
    input  logic        load_flag_i,
    input  logic        LSU_signed_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_imm_i,
    input  logic [31:0] wb_data_ex_i,
    output logic        lsu_hold_flag_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        wb_flag_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic [1:0]  r_type;
    logic        r_signed;
    logic [1:0]  r_off;
    logic        r_lwb_flag;
    logic [4:0]  r_lwb_addr;
    logic        r_misalign;
    logic        r_bus_err;
    logic        r_wb_flag;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;

    logic [31:0] w_ea;
    logic        w_access;
    logic        w_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load_data;
    logic        w_timeout;

    assign w_ea     = operand_a_i + operand_imm_i;
    assign w_access = load_flag_i | store_flag_i;

    always_comb begin
        w_misalign = 1'b0;
        w_wstrb    = 4'hF;
        w_wdata    = operand_b_i;
        case (LSU_type_i)
            2'b00: begin
                w_wstrb = 4'b0001 << w_ea[1:0];
                w_wdata = {4{operand_b_i[7:0]}};
            end
            2'b01: begin
                w_misalign = w_ea[0];
                w_wstrb    = 4'b0011 << w_ea[1:0];
                w_wdata    = {2{operand_b_i[15:0]}};
            end
            default: w_misalign = |w_ea[1:0];
        endcase
    end

    // Aligned accesses only: shifting by the byte offset brings the lane to bit 0.
    assign w_lane = mem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_lane;
        case (r_type)
            2'b00:   w_load_data = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load_data = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    assign w_timeout = (r_cnt == T_LAST);

    always_comb begin
        if (r_state == IDLE)
            lsu_hold_flag_o = w_access & ~w_misalign;
        else
            lsu_hold_flag_o = ~mem_ack_i & ~w_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_type      <= '0;
            r_signed    <= 1'b0;
            r_off       <= '0;
            r_lwb_flag  <= 1'b0;
            r_lwb_addr  <= '0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_wb_flag   <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_access) begin
                        r_wb_flag <= wb_flag_i;
                        r_wb_addr <= wb_addr_i;
                        r_wb_data <= wb_data_ex_i;
                    end else if (w_misalign) begin
                        r_misalign <= 1'b1;
                        r_wb_flag  <= 1'b0;
                    end else begin
                        r_mem_addr  <= {w_ea[31:2], 2'b00};
                        r_mem_we    <= store_flag_i;
                        r_mem_wstrb <= store_flag_i ? w_wstrb : 4'h0;
                        r_mem_wdata <= w_wdata;
                        r_type      <= LSU_type_i;
                        r_signed    <= LSU_signed_i;
                        r_off       <= w_ea[1:0];
                        r_lwb_flag  <= wb_flag_i;
                        r_lwb_addr  <= wb_addr_i;
                        r_mem_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_wb_flag   <= 1'b0;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                        if (!r_mem_we) begin
                            r_wb_flag <= r_lwb_flag;
                            r_wb_addr <= r_lwb_addr;
                            r_wb_data <= w_load_data;
                        end else begin
                            r_wb_flag <= 1'b0;
                        end
                    end else begin
                        r_wb_flag <= 1'b0;
                        if (w_timeout) begin
                            r_mem_req <= 1'b0;
                            r_bus_err <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wstrb_o = r_mem_wstrb;
    assign misalign_o  = r_misalign;
    assign bus_err_o   = r_bus_err;
    assign wb_flag_o   = r_wb_flag;
    assign wb_addr_o   = r_wb_addr;
    assign wb_data_o   = r_wb_data;

endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - directed bench for lsu_stage with a write-back scoreboard.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_flag_i;
    logic [1:0]  LSU_type_i;
    logic        store_flag_i;
    logic        load_flag_i;
    logic        LSU_signed_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [31:0] operand_imm_i;
    logic [31:0] wb_data_ex_i;
    logic        lsu_hold_flag_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        misalign_o;
    logic        bus_err_o;
    logic        wb_flag_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t sb[$];
    wb_t exp_wb;
    int  n_checks = 0;
    int  n_errors = 0;
    int  hold_cnt;
    int  req_cnt;

    lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .wb_flag_i(wb_flag_i), .LSU_type_i(LSU_type_i),
        .store_flag_i(store_flag_i), .load_flag_i(load_flag_i),
        .LSU_signed_i(LSU_signed_i), .wb_addr_i(wb_addr_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .operand_imm_i(operand_imm_i), .wb_data_ex_i(wb_data_ex_i),
        .lsu_hold_flag_o(lsu_hold_flag_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .wb_flag_o(wb_flag_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_flag_i     = 1'b0;
        LSU_type_i    = 2'b00;
        store_flag_i  = 1'b0;
        load_flag_i   = 1'b0;
        LSU_signed_i  = 1'b0;
        wb_addr_i     = '0;
        operand_a_i   = '0;
        operand_b_i   = '0;
        operand_imm_i = '0;
        wb_data_ex_i  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [31:0] imm,
                              input logic [1:0] typ, input logic sgn, input logic [4:0] rd);
        idle_inputs();
        load_flag_i   = 1'b1;
        operand_a_i   = a;
        operand_imm_i = imm;
        LSU_type_i    = typ;
        LSU_signed_i  = sgn;
        wb_flag_i     = 1'b1;
        wb_addr_i     = rd;
    endtask

    // Scoreboard: every write-back the DUT emits must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_flag_o) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_wb = sb.pop_front();
                check("wb_addr", {27'd0, wb_addr_o}, {27'd0, exp_wb.addr});
                check("wb_data", wb_data_o, exp_wb.data);
            end
        end
    end

    initial begin
        idle_inputs();
        rst         = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("rst_hold",  {31'd0, lsu_hold_flag_o}, 32'd0);
        check("rst_wbf",   {31'd0, wb_flag_o}, 32'd0);
        check("rst_wbd",   wb_data_o, 32'd0);
        check("rst_addr",  mem_addr_o, 32'd0);
        check("rst_flags", {28'd0, misalign_o, bus_err_o, mem_we_o, 1'b0}, 32'd0);

        // Pass-through
        next_cycle();
        wb_flag_i    = 1'b1;
        wb_addr_i    = 5'd5;
        wb_data_ex_i = 32'h1234;
        sb.push_back('{addr: 5'd5, data: 32'h1234});
        @(negedge clk);
        check("pt_hold", {31'd0, lsu_hold_flag_o}, 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("pt_wbf", {31'd0, wb_flag_o}, 32'd1);

        // Signed then unsigned byte load, ack on first REQ cycle
        for (int s = 1; s >= 0; s--) begin
            next_cycle();
            drive_load(32'h1000, 32'd3, 2'b00, s[0], 5'd7);
            sb.push_back('{addr: 5'd7, data: (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080});
            @(negedge clk);
            check("lb_hold_idle", {31'd0, lsu_hold_flag_o}, 32'd1);
            next_cycle();
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'h80FF_FFFF;
            @(negedge clk);
            check("lb_req",      {31'd0, mem_req_o}, 32'd1);
            check("lb_addr",     mem_addr_o, 32'h1000);
            check("lb_wstrb",    {28'd0, mem_wstrb_o}, 32'd0);
            check("lb_hold_ack", {31'd0, lsu_hold_flag_o}, 32'd0);
            next_cycle();
            mem_ack_i = 1'b0;
            idle_inputs();
            @(negedge clk);
            check("lb_wbf",   {31'd0, wb_flag_o}, 32'd1);
            check("lb_reqlo", {31'd0, mem_req_o}, 32'd0);
        end

        // Half store, ack on the 4th REQ cycle
        next_cycle();
        idle_inputs();
        store_flag_i  = 1'b1;
        operand_a_i   = 32'h2000;
        operand_imm_i = 32'd2;
        operand_b_i   = 32'hDEAD_BEEF;
        LSU_type_i    = 2'b01;
        hold_cnt      = 0;
        @(negedge clk);
        if (lsu_hold_flag_o) hold_cnt++;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_ack_i = (i == 3);
            @(negedge clk);
            if (lsu_hold_flag_o) hold_cnt++;
            check("sh_wbf", {31'd0, wb_flag_o}, 32'd0);
        end
        check("sh_we",    {31'd0, mem_we_o}, 32'd1);
        check("sh_wstrb", {28'd0, mem_wstrb_o}, 32'hC);
        check("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
        check("sh_addr",  mem_addr_o, 32'h2000);
        check("sh_hold_cycles", hold_cnt, 32'd4);
        next_cycle();
        mem_ack_i = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("sh_wbf_after", {31'd0, wb_flag_o}, 32'd0);
        check("sh_reqlo",     {31'd0, mem_req_o}, 32'd0);

        // Misaligned word load
        next_cycle();
        drive_load(32'h3000, 32'd1, 2'b10, 1'b0, 5'd9);
        @(negedge clk);
        check("mis_hold", {31'd0, lsu_hold_flag_o}, 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("mis_pulse", {31'd0, misalign_o}, 32'd1);
        check("mis_req",   {31'd0, mem_req_o}, 32'd0);
        check("mis_wbf",   {31'd0, wb_flag_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("mis_pulse_end", {31'd0, misalign_o}, 32'd0);

        // Timeout with TIMEOUT_CYCLES=4
        next_cycle();
        drive_load(32'h4000, 32'd0, 2'b10, 1'b0, 5'd11);
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            if (mem_req_o) req_cnt++;
            check("to_noerr", {31'd0, bus_err_o}, 32'd0);
        end
        check("to_hold_last", {31'd0, lsu_hold_flag_o}, 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("to_req_cycles", req_cnt, 32'd4);
        check("to_req_lo",     {31'd0, mem_req_o}, 32'd0);
        check("to_buserr",     {31'd0, bus_err_o}, 32'd1);
        check("to_wbf",        {31'd0, wb_flag_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("to_buserr_end", {31'd0, bus_err_o}, 32'd0);

        // Reset mid-access, then a late ack
        next_cycle();
        drive_load(32'h5000, 32'd4, 2'b10, 1'b0, 5'd12);
        next_cycle();
        @(negedge clk);
        check("rm_req", {31'd0, mem_req_o}, 32'd1);
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst         = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        check("rm_req_lo", {31'd0, mem_req_o}, 32'd0);
        check("rm_hold",   {31'd0, lsu_hold_flag_o}, 32'd0);
        check("rm_addr",   mem_addr_o, 32'd0);
        check("rm_wbf",    {31'd0, wb_flag_o}, 32'd0);
        next_cycle();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("rm_late_wbf", {31'd0, wb_flag_o}, 32'd0);
        check("rm_late_wbd", wb_data_o, 32'd0);
        check("sb_empty",    sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Receiving end of the EX→LSU pipeline register interface.
- Takes the registered EX outputs: control flags, write-back address, operands, immediate and the EX result.
- Load/store instructions: computes the effective address, drives a single-outstanding request/acknowledge data-memory port, byte-aligns and extends load data, and stalls upstream via a hold flag until the access completes.
- All other instructions: forwards the EX result to the write-back register with one cycle latency.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without mem_ack_i before the access is aborted with bus_err_o (1..65535).

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- wb_flag_i  in  1  instruction writes a register.
- LSU_type_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- store_flag_i  in  1  store instruction.
- load_flag_i  in  1  load instruction.
- LSU_signed_i  in  1  1 = sign-extend load, 0 = zero-extend.
- wb_addr_i  in  5  destination register.
- operand_a_i  in  32  base address.
- operand_b_i  in  32  store data.
- operand_imm_i  in  32  address offset.
- wb_data_ex_i  in  32  EX result for non-load instructions.
- lsu_hold_flag_o  out  1  to controller: hold EX and earlier stages.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word-aligned address.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_wstrb_o  out  4  byte strobes (0 for loads).
- mem_ack_i  in  1  access complete; load data valid this cycle.
- mem_rdata_i  in  32  read word.
- misalign_o  out  1  1-cycle pulse: misaligned access dropped.
- bus_err_o  out  1  1-cycle pulse: access timed out.
- wb_flag_o  out  1  to WB stage.
- wb_addr_o  out  5  to WB stage.
- wb_data_o  out  32  to WB stage.

Behaviour:
- Reset values:
  - State IDLE; timeout counter 0; latched request registers 0.
  - All outputs 0.
  - Reset mid-access drops mem_req_o on the next edge; no write-back results from the aborted access.
- Address and alignment:
  - ea = operand_a_i + operand_imm_i, modulo 2^32.
  - access = load_flag_i | store_flag_i.
  - Misaligned: half with ea[0]=1, or word/11 with ea[1:0]≠0.
- Store lanes:
  - Byte: wstrb = 4'b0001<<ea[1:0], wdata = {4{b[7:0]}}.
  - Half: wstrb = 4'b0011<<ea[1:0], wdata = {2{b[15:0]}}.
  - Word: wstrb = 4'hF, wdata = b.
- Load lanes:
  - Select byte/half at ea[1:0] from mem_rdata_i.
  - Extend to 32 bits per the latched signed flag.
- FSM IDLE:
  - No access: wb_flag_o/wb_addr_o/wb_data_o <= wb_flag_i/wb_addr_i/wb_data_ex_i; hold=0.
  - Aligned access:
    - Latch mem_addr={ea[31:2],2'b00}, we, wstrb, wdata, type, signed, ea[1:0], wb_flag, wb_addr.
    - Set mem_req_o<=1, clear counter, go REQ.
    - hold=1 combinationally; wb_flag_o<=0 (bubble).
  - Misaligned access: misalign_o<=1 for one cycle, wb_flag_o<=0, no request, stay IDLE, hold=0.
- FSM REQ:
  - mem_req_o and all mem_* outputs held stable.
  - hold = !mem_ack_i.
  - On mem_ack_i:
    - mem_req_o<=0, go IDLE.
    - Load: wb_flag_o<=latched wb_flag, wb_addr_o<=latched addr, wb_data_o<=extended data.
    - Store: wb_flag_o<=0.
  - Without ack:
    - wb_flag_o<=0, counter++.
    - When counter==TIMEOUT_CYCLES-1: mem_req_o<=0, bus_err_o<=1 for one cycle, wb_flag_o<=0, go IDLE, hold=0 that cycle.
  - Ack and timeout in the same cycle: ack wins.
- Timing:
  - Memory access occupies the stage for at least 2 cycles: 1 stall cycle plus the ack cycle.
  - Non-memory instructions: 1 cycle, no stall.
  - mem_ack_i outside REQ is ignored.
  - Inputs are stable while hold=1; the block does not re-sample them in REQ.

Test Plan:
- Pass-through: wb_flag_i=1, wb_addr_i=5, wb_data_ex_i=0x1234, no access -> next cycle wb_flag_o=1, wb_addr_o=5, wb_data_o=0x1234; hold stays 0.
- Signed byte load: a=0x1000, imm=3, type=00, signed=1, rdata=0x80FF_FFFF, ack on 1st REQ cycle -> mem_addr_o=0x1000, wstrb=0, hold high 1 cycle; wb_data_o=0xFFFF_FF80, wb_flag_o=1. Same with signed=0 -> 0x0000_0080.
- Half store: a=0x2000, imm=2, b=0xDEAD_BEEF, type=01 -> mem_we_o=1, wstrb=4'b1100, wdata=0xBEEF_BEEF; ack after 3 cycles -> hold high 4 cycles, wb_flag_o stays 0.
- Misaligned word load: ea=0x3001, type=10 -> misalign_o pulses 1 cycle, mem_req_o never asserts, wb_flag_o=0, hold=0.
- Timeout: TIMEOUT_CYCLES=4, load, no ack -> mem_req_o high exactly 4 cycles, bus_err_o pulses on the following cycle, state returns IDLE, wb_flag_o=0.
- Reset mid-access: assert rst during REQ -> next cycle mem_req_o=0, hold=0, all outputs 0; a late ack after reset has no effect.
